parity_framer: RTL and testbench

Parametrised serial even/odd parity encoder. Accepts a stream of DATA_W data bits over a valid/ready handshake, appends one parity bit as the MSB, and presents the DATA_W+1-bit frame both in parallel and as a back-pressured serial stream. It is the next generation of the fixed 15+1-bit parity encoder, and sits between a bit source and a channel or serial link model in the error-correction chain.

---
 rtl/parity_framer.sv | 114 +++++++++++
 tb/tb_parity_framer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/parity_framer.sv
// Serial even/odd parity framer: collects DATA_W bits over valid/ready, appends
// a parity MSB, and presents the frame in parallel and as a back-pressured stream.
module parity_framer #(
  parameter int DATA_W = 15,
  parameter bit ODD    = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              in_ready,
  output logic [DATA_W:0]   frame_out,
  output logic              frame_valid,
  output logic              out_valid,
  output logic              out_bit,
  output logic              out_last,
  input  logic              out_ready
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   idx;
  logic [DATA_W-1:0]  data;
  logic [DATA_W-1:0]  data_next;
  logic               par;
  logic               accept;
  logic               xfer;
  logic               last_accept;
  logic               last_xfer;

  // Handshake and serial outputs decode registered state only, so there is no
  // combinational path from the input side to the output side or back.
  assign in_ready    = (state == COLLECT);
  assign out_valid   = (state == EMIT);
  assign out_last    = out_valid && (idx == CNT_W'(DATA_W));
  assign out_bit     = out_valid & frame_out[idx];

  assign accept      = in_valid & in_ready;
  assign xfer        = out_valid & out_ready;
  assign last_accept = accept && (cnt == CNT_W'(DATA_W - 1));
  assign last_xfer   = xfer && (idx == CNT_W'(DATA_W));

  // NOTE: every signal written in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    data_next = data;
    for (int i = 0; i < DATA_W; i++) begin
      if (accept && (cnt == CNT_W'(i))) begin
        data_next[i] = in_bit;
      end
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      COLLECT: if (last_accept) state_next = EMIT;
      EMIT:    if (last_xfer)   state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: the data holding register is not reset; every bit is rewritten
  // before the frame that uses it is loaded, so a reset would only cost logic.
  always_ff @(posedge clk) begin
    data <= data_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      idx         <= '0;
      par         <= 1'b0;
      frame_out   <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (accept) begin
        if (last_accept) begin
          // The last bit is folded in here; ODD only inverts the final result.
          frame_out   <= {par ^ in_bit ^ ODD, data_next};
          frame_valid <= 1'b1;
          cnt         <= '0;
          par         <= 1'b0;
        end else begin
          cnt <= cnt + CNT_W'(1);
          par <= par ^ in_bit;
        end
      end
      if (xfer) begin
        idx <= last_xfer ? '0 : idx + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_parity_framer.sv
// Self-checking bench for parity_framer: constant vectors, reset corners, an
// 8-bit width sequence and random handshakes against a frame-level model.
module tb_parity_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, in_bit, out_ready;
  logic in_ready_e, fv_e, ov_e, ob_e, ol_e;
  logic in_ready_o, fv_o, ov_o, ob_o, ol_o;
  logic [15:0] fo_e, fo_o;

  logic in_valid8, in_bit8, out_ready8;
  logic in_ready8e, fv8e, ov8e, ob8e, ol8e;
  logic in_ready8o, fv8o, ov8o, ob8o, ol8o;
  logic [8:0] fo8e, fo8o;

  parity_framer #(.DATA_W(15), .ODD(1'b0)) u_even (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready_e),
    .frame_out(fo_e), .frame_valid(fv_e), .out_valid(ov_e), .out_bit(ob_e),
    .out_last(ol_e), .out_ready(out_ready));
  parity_framer #(.DATA_W(15), .ODD(1'b1)) u_odd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready_o),
    .frame_out(fo_o), .frame_valid(fv_o), .out_valid(ov_o), .out_bit(ob_o),
    .out_last(ol_o), .out_ready(out_ready));
  parity_framer #(.DATA_W(8), .ODD(1'b0)) u_w8e (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_bit(in_bit8), .in_ready(in_ready8e),
    .frame_out(fo8e), .frame_valid(fv8e), .out_valid(ov8e), .out_bit(ob8e),
    .out_last(ol8e), .out_ready(out_ready8));
  parity_framer #(.DATA_W(8), .ODD(1'b1)) u_w8o (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_bit(in_bit8), .in_ready(in_ready8o),
    .frame_out(fo8o), .frame_valid(fv8o), .out_valid(ov8o), .out_bit(ob8o),
    .out_last(ol8o), .out_ready(out_ready8));

  int n_cmp = 0;
  int n_bad = 0;

  // Frame-level reference model: a queue of collected bits and the frame
  // currently being sent, with parity derived from the count of ones.
  logic        mdl_bits[$];
  bit          emitting;
  int          pos;
  logic [15:0] emit_even, emit_odd;
  logic [15:0] exp_fo_e, exp_fo_o;
  logic        exp_fv;
  int          fv_seen;
  logic [15:0] cap, cap_o;

  typedef struct {
    logic [14:0] data;
    logic [15:0] exp_e;
    logic [15:0] exp_o;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    check("in_ready", 32'(in_ready_e), 32'(!emitting));
    check("in_ready_odd", 32'(in_ready_o), 32'(!emitting));
    check("out_valid", 32'(ov_e), 32'(emitting));
    check("out_valid_odd", 32'(ov_o), 32'(emitting));
    check("out_last", 32'(ol_e), 32'(emitting && pos == 15));
    if (emitting) begin
      check("out_bit", 32'(ob_e), 32'(emit_even[pos]));
      check("out_bit_odd", 32'(ob_o), 32'(emit_odd[pos]));
    end
    check("frame_out", 32'(fo_e), 32'(exp_fo_e));
    check("frame_out_odd", 32'(fo_o), 32'(exp_fo_o));
    check("frame_valid", 32'(fv_e), 32'(exp_fv));
    check("frame_valid_odd", 32'(fv_o), 32'(exp_fv));
    if (fv_e) fv_seen++;
  endtask

  // One clock cycle: compare outputs, drive inputs, advance the model.
  task automatic step(input logic v, input logic b, input logic r, input logic rst);
    compare_all();
    rst_n = rst; in_valid = v; in_bit = b; out_ready = r;
    exp_fv = 1'b0;
    if (!rst) begin
      mdl_bits.delete();
      emitting = 0; pos = 0;
      exp_fo_e = '0; exp_fo_o = '0;
    end else if (!emitting) begin
      if (v) begin
        mdl_bits.push_back(b);
        if (mdl_bits.size() == 15) begin
          logic [14:0] d;
          logic        p;
          for (int i = 0; i < 15; i++) d[i] = mdl_bits[i];
          p = ($countones(d) % 2) == 1;
          emit_even = {p, d};
          emit_odd  = {~p, d};
          exp_fo_e = emit_even; exp_fo_o = emit_odd;
          exp_fv = 1'b1;
          emitting = 1; pos = 0;
          mdl_bits.delete();
        end
      end
    end else if (r) begin
      cap[pos] = ob_e;
      cap_o[pos] = ob_o;
      if (pos == 15) begin
        emitting = 0; pos = 0;
      end else begin
        pos++;
      end
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [14:0] d);
    for (int i = 0; i < 15; i++) step(1'b1, d[i], 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
  endtask

  initial begin
    int fv0;
    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    in_valid8 = 1'b0; in_bit8 = 1'b0; out_ready8 = 1'b0;
    emitting = 0; pos = 0; exp_fo_e = '0; exp_fo_o = '0; exp_fv = 1'b0; fv_seen = 0;
    cap = '0; cap_o = '0;

    vecs[0] = '{15'h74B4, 16'h74B4, 16'hF4B4};
    vecs[1] = '{15'h7FFF, 16'hFFFF, 16'h7FFF};
    vecs[2] = '{15'h0000, 16'h0000, 16'h8000};
    vecs[3] = '{15'h0001, 16'h8001, 16'h0001};
    vecs[4] = '{15'h5555, 16'h5555, 16'hD555};

    repeat (2) @(negedge clk);
    check("rst_out_bit", 32'(ob_e), 32'(0));
    check("rst_out_last", 32'(ol_e), 32'(0));
    check("rst_w8_frame", 32'(fo8e), 32'(0));
    check("rst_w8_in_ready", 32'(in_ready8e), 32'(1));

    // Constant vectors, sent back to back with in_valid held high.
    for (int k = 0; k < 5; k++) begin
      fv0 = fv_seen;
      send_frame(vecs[k].data);
      check($sformatf("vec%0d_frame_even", k), 32'(fo_e), 32'(vecs[k].exp_e));
      check($sformatf("vec%0d_frame_odd", k), 32'(fo_o), 32'(vecs[k].exp_o));
      check($sformatf("vec%0d_serial_even", k), 32'(cap), 32'(vecs[k].exp_e));
      check($sformatf("vec%0d_serial_odd", k), 32'(cap_o), 32'(vecs[k].exp_o));
      check($sformatf("vec%0d_fv_pulses", k), 32'(fv_seen - fv0), 32'(1));
    end

    // Reset after 7 accepted bits: the partial frame must vanish.
    for (int i = 0; i < 7; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    fv0 = fv_seen;
    send_frame(vecs[0].data);
    check("rst_collect_frame", 32'(fo_e), 32'(16'h74B4));
    check("rst_collect_fv", 32'(fv_seen - fv0), 32'(1));

    // Reset during EMIT at idx 5.
    for (int i = 0; i < 15; i++) step(1'b1, vecs[1].data[i], 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
    check("emit_idx5_valid", 32'(ov_e), 32'(1));
    check("emit_idx5_bit", 32'(ob_e), 32'(1));
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("rst_emit_out_valid", 32'(ov_e), 32'(0));
    check("rst_emit_frame", 32'(fo_e), 32'(0));
    check("rst_emit_frame_odd", 32'(fo_o), 32'(0));
    check("rst_emit_in_ready", 32'(in_ready_e), 32'(1));
    check("rst_emit_out_bit", 32'(ob_e), 32'(0));
    step(1'b0, 1'b0, 1'b1, 1'b1);

    // Random gaps on in_valid and ~50% out_ready.
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'b1);
    end
    for (int c = 0; c < 100 && emitting; c++) step(1'b0, 1'b0, 1'b1, 1'b1);
    check("drain_done", 32'(emitting), 32'(0));
    compare_all();

    // Width 8: 8'hA5 LSB first, with a stall in EMIT.
    begin
      logic [7:0] d8;
      logic [8:0] exp8, got8e, got8o;
      int         n;
      bit         done;
      d8 = 8'hA5; exp8 = 9'h0A5; got8e = '0; got8o = '0; n = 0; done = 0;
      for (int i = 0; i < 8; i++) begin
        check("w8_in_ready", 32'(in_ready8e), 32'(1));
        in_valid8 = 1'b1; in_bit8 = d8[i]; out_ready8 = 1'b1;
        @(negedge clk);
      end
      check("w8_fv_even", 32'(fv8e), 32'(1));
      check("w8_fv_odd", 32'(fv8o), 32'(1));
      check("w8_frame_even", 32'(fo8e), 32'(9'h0A5));
      check("w8_frame_odd", 32'(fo8o), 32'(9'h1A5));
      for (int c = 0; c < 30 && !done; c++) begin
        out_ready8 = !(c >= 3 && c <= 5);
        if (c == 5) begin
          check("w8_stall_bit", 32'(ob8e), 32'(exp8[n]));
          check("w8_stall_valid", 32'(ov8e), 32'(1));
        end
        if (ov8e) check("w8_in_ready_emit", 32'(in_ready8e), 32'(0));
        if (ov8e && out_ready8 && n < 9) begin
          got8e[n] = ob8e;
          got8o[n] = ob8o;
          check("w8_out_last", 32'(ol8e), 32'(n == 8));
          if (ol8e) done = 1;
          n++;
        end
        @(negedge clk);
      end
      check("w8_transfers", 32'(n), 32'(9));
      check("w8_serial_even", 32'(got8e), 32'(9'h0A5));
      check("w8_serial_odd", 32'(got8o), 32'(9'h1A5));
      check("w8_back_ready", 32'(in_ready8e), 32'(1));
      check("w8_back_valid", 32'(ov8e), 32'(0));
      in_valid8 = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
